// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream
// (16-bit little-endian word count, then 4 bytes per little-endian word)
// and holds the core while loading.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter logic [31:0] StartAddr = 32'h0000_0000,
    parameter int unsigned SizeBytes = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        busy,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned MaxWords = SizeBytes / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        next_active;

    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] asm_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  xor_acc;
`endif

    logic        fire;
    logic        start_ok;
    logic        last_byte;
    logic        last_word;
    logic [15:0] len_full;

    assign fire      = in_valid && in_ready;
    assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign last_byte = fire && (state == S_DATA) && (byte_cnt == 2'd3);
    assign last_word = (word_idx == len - 16'd1);
    assign len_full  = {in_data, len[7:0]};

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state  = state;
        next_active = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (fire) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (fire) begin
                    if (len_full == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        next_state = S_CHK;
`else
                        next_state = S_DONE;
`endif
                    end else if (17'(len_full) > 17'(MaxWords)) begin
                        next_state = S_ERR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (last_byte && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state = S_CHK;
`else
                    next_state = S_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (fire) next_state = (in_data == xor_acc) ? S_DONE : S_ERR;
            end
`endif
            default: next_state = S_IDLE;
        endcase
        case (next_state)
            S_LEN_LO, S_LEN_HI, S_DATA: next_active = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:                      next_active = 1'b1;
`endif
            default:                    next_active = 1'b0;
        endcase
    end

    // Registered status and IMem write port
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            we       <= 1'b0;
            waddr    <= 32'h0;
            wdata    <= 32'h0;
        end else begin
            in_ready <= next_active;
            busy     <= next_active;
            cpu_hold <= next_active;
            done     <= (next_state == S_DONE);
            error    <= (next_state == S_ERR);
            we       <= last_byte;
            if (last_byte) begin
                wdata <= {in_data, asm_word};
                waddr <= StartAddr + 32'({word_idx, 2'b00});
            end
        end
    end

    // Header capture, word assembly and counters
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            len      <= 16'h0;
            word_idx <= 16'h0;
            byte_cnt <= 2'd0;
            asm_word <= 24'h0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_acc  <= 8'h0;
`endif
        end else if (fire) begin
            case (state)
                S_LEN_LO: len[7:0]  <= in_data;
                S_LEN_HI: len[15:8] <= in_data;
                S_DATA: begin
                    case (byte_cnt)
                        2'd0:    asm_word[7:0]   <= in_data;
                        2'd1:    asm_word[15:8]  <= in_data;
                        2'd2:    asm_word[23:16] <= in_data;
                        default: asm_word        <= asm_word;
                    endcase
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) word_idx <= word_idx + 16'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    xor_acc <= xor_acc ^ in_data;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: randomized streams checked against a
// byte-list model of the expected IMem image and final status.
module tb_imem_loader;

    localparam int unsigned MAXW = 64;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_BUILD = 1'b1;
`else
    localparam bit CHK_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] obs_addr[$];
    logic [31:0] obs_data[$];
    logic [7:0]  pay[$];
    logic [7:0]  strm[$];

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Capture every IMem write, sampled mid-cycle
    always @(negedge clk) begin
        if (we) begin
            obs_addr.push_back(waddr);
            obs_data.push_back(wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_we"},       32'(we),       32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_error"},    32'(error),    32'd0);
        check({tag, "_waddr"},    waddr,         32'd0);
        check({tag, "_wdata"},    wdata,         32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Push strm into the DUT; returns at the negedge after the last accepted byte
    task automatic send_stream(input int stall_pct, input string tag);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < strm.size() && cyc < 4000) begin
            @(negedge clk);
            in_valid = ($urandom_range(99) >= 32'(stall_pct));
            in_data  = strm[idx];
            acc      = in_valid && in_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_bytes_accepted"}, 32'(idx), 32'(strm.size()));
    endtask

    // Full load of header + pay (+ checksum) against the image model
    task automatic run_load(input logic [15:0] n, input int stall_pct, input bit bad_chk,
                            input string tag);
        bit          oversize;
        bit          exp_err;
        int          nwords;
        int          c;
        logic [7:0]  x;
        logic [31:0] exp_word;
        oversize = (32'(n) > MAXW);
        exp_err  = oversize || (CHK_BUILD && bad_chk);
        nwords   = oversize ? 0 : int'(n);
        strm.delete();
        strm.push_back(n[7:0]);
        strm.push_back(n[15:8]);
        x = 8'h00;
        if (!oversize) begin
            for (int i = 0; i < 4 * nwords; i++) begin
                strm.push_back(pay[i]);
                x ^= pay[i];
            end
            if (CHK_BUILD) strm.push_back(bad_chk ? (x ^ 8'h01) : x);
        end
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_stream(stall_pct, tag);
        if (CHK_BUILD || n == 16'd0 || oversize)
            check({tag, "_term_next_cycle"}, 32'(done || error), 32'd1);
        c = 0;
        while (!(done || error) && c < 200) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_nwrites"}, 32'(obs_addr.size()), 32'(nwords));
        for (int i = 0; i < nwords && i < obs_addr.size(); i++) begin
            exp_word = {pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i]};
            check($sformatf("%s_addr%0d", tag, i), obs_addr[i], 32'(4 * i));
            check($sformatf("%s_data%0d", tag, i), obs_data[i], exp_word);
        end
        check({tag, "_done"},     32'(done),     32'(!exp_err));
        check({tag, "_error"},    32'(error),    32'(exp_err));
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] n;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_held");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_released");

        // Single word DEADBEEF
        pay = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(16'd1, 0, 1'b0, "single");

        // Full image, incrementing bytes
        pay.delete();
        for (int i = 0; i < 256; i++) pay.push_back(8'(i));
        run_load(16'd64, 0, 1'b0, "full");
        if (obs_data.size() == 64) begin
            check("full_last_addr", obs_addr[63], 32'h0000_00FC);
            check("full_last_data", obs_data[63], 32'hFFFE_FDFC);
        end else begin
            check("full_write_count", 32'(obs_data.size()), 32'd64);
        end

        // Oversize header and zero length
        run_load(16'd65, 0, 1'b0, "oversize");
        run_load(16'd0, 0, 1'b0, "zero");

        // Random images, back-to-back then with random stalls
        for (int r = 0; r < 4; r++) begin
            n = 16'($urandom_range(1, MAXW));
            pay.delete();
            for (int i = 0; i < 4 * int'(n); i++) pay.push_back(8'($urandom));
            run_load(n, 0, 1'b0, $sformatf("rnd%0d_b2b", r));
            run_load(n, 60, 1'b0, $sformatf("rnd%0d_stall", r));
        end

        // Reset after two data bytes: no write, reset outputs, then a clean load
        strm = '{8'h02, 8'h00, 8'hAA, 8'hBB};
        obs_addr.delete();
        obs_data.delete();
        pulse_start();
        send_stream(0, "midrst");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_no_write", 32'(obs_addr.size()), 32'd0);
        check_idle_outputs("midrst");
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        run_load(16'd2, 30, 1'b0, "after_rst");

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum 44 matches 11^22^33^44; 45 does not
        pay = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(16'd1, 0, 1'b0, "chk_ok");
        run_load(16'd1, 0, 1'b1, "chk_bad");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
